aes_ip_load_seq: RTL and testbench

Sequencer sitting in front of the ip_send_recv engine; drives the engine's byte-serial configuration and data ports.
- On command it loads the 128-bit AES key, then the NUM_ADDR-entry local address table, one byte per clock.
- It then forwards upstream packet bytes into the engine, honouring the engine's busy back-pressure.
- Replaces hand-sequenced bench/host loading with one reusable controller.

---
 rtl/aes_ip_load_seq_if.sv | 19 +
 rtl/aes_ip_load_seq.sv | 149 ++++++++++++++
 tb/tb_aes_ip_load_seq.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_ip_load_seq_if.sv
// Packet byte handshake between upstream source and the load sequencer.
// Source side drives valid/data, sequencer side returns ready.
interface aes_ip_load_seq_if;
  logic       pkt_valid;
  logic [7:0] pkt_data;
  logic       pkt_ready;

  modport master (
    output pkt_valid,
    output pkt_data,
    input  pkt_ready
  );

  modport slave (
    input  pkt_valid,
    input  pkt_data,
    output pkt_ready
  );
endinterface

// File: rtl/aes_ip_load_seq.sv
// Loads AES key and address table into ip_send_recv, then streams packets.
// Optional macro AES_SEQ_BYTE_CNT_EN adds the stream_bytes counter output.
module aes_ip_load_seq #(
  parameter int NUM_ADDR  = 8,
  parameter int KEY_BYTES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic [127:0]        cfg_key,
  input  logic                addr_wr,
  input  logic [2:0]          addr_idx,
  input  logic [31:0]         addr_data,
  aes_ip_load_seq_if.slave    pkt,
  output logic [7:0]          eng_in,
  output logic                eng_key_enable,
  output logic                eng_address_enable,
  output logic                eng_ready,
  input  logic                eng_busy,
  output logic                cfg_busy,
`ifdef AES_SEQ_BYTE_CNT_EN
  output logic                cfg_done,
  output logic [31:0]         stream_bytes
`else
  output logic                cfg_done
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_KEY,
    LOAD_ADDR,
    STREAM
  } state_t;

  localparam logic [5:0] KEY_LAST = 6'(KEY_BYTES - 1);
  localparam logic [5:0] ADDR_LEN = 6'(NUM_ADDR * 4);
  localparam logic [3:0] TAB_LEN  = 4'(NUM_ADDR);

  state_t        state;
  logic [127:0]  key_sr;
  logic [31:0]   tab    [8];
  logic [31:0]   shadow [8];
  logic [5:0]    cnt;
  logic [31:0]   cur;
  logic          start_ok;
  logic          accept;

  assign start_ok = cfg_start &
                    ((state == IDLE) || (state == STREAM));

  // A restart in the same cycle would lose the byte, so hold it off.
  assign pkt.pkt_ready = (state == STREAM) & ~eng_busy & ~cfg_start;
  assign accept        = pkt.pkt_valid & pkt.pkt_ready;
  assign cur           = shadow[cnt[4:2]];

  // Host-visible address table, writable in any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) tab[i] <= '0;
    end else if (addr_wr && ({1'b0, addr_idx} < TAB_LEN)) begin
      tab[addr_idx] <= addr_data;
    end
  end

  // Load/stream sequencer with registered engine-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      key_sr             <= '0;
      cnt                <= '0;
      eng_in             <= '0;
      eng_key_enable     <= 1'b0;
      eng_address_enable <= 1'b0;
      eng_ready          <= 1'b0;
      cfg_busy           <= 1'b0;
      cfg_done           <= 1'b0;
      for (int i = 0; i < 8; i++) shadow[i] <= '0;
    end else if (start_ok) begin
      shadow             <= tab;
      key_sr             <= cfg_key << 8;
      eng_in             <= cfg_key[127:120];
      eng_key_enable     <= 1'b1;
      eng_address_enable <= 1'b0;
      eng_ready          <= 1'b0;
      cfg_busy           <= 1'b1;
      cfg_done           <= 1'b0;
      cnt                <= 6'd1;
      state              <= LOAD_KEY;
    end else begin
      unique case (state)
        IDLE: begin
          eng_key_enable     <= 1'b0;
          eng_address_enable <= 1'b0;
          eng_ready          <= 1'b0;
        end
        LOAD_KEY: begin
          eng_in         <= key_sr[127:120];
          key_sr         <= key_sr << 8;
          eng_key_enable <= 1'b1;
          if (cnt == KEY_LAST) begin
            cnt   <= '0;
            state <= LOAD_ADDR;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        LOAD_ADDR: begin
          eng_key_enable <= 1'b0;
          if (cnt == ADDR_LEN) begin
            eng_address_enable <= 1'b0;
            cfg_busy           <= 1'b0;
            cfg_done           <= 1'b1;
            cnt                <= '0;
            state              <= STREAM;
          end else begin
            eng_address_enable <= 1'b1;
            cnt                <= cnt + 6'd1;
            unique case (cnt[1:0])
              2'd0: eng_in <= cur[31:24];
              2'd1: eng_in <= cur[23:16];
              2'd2: eng_in <= cur[15:8];
              2'd3: eng_in <= cur[7:0];
            endcase
          end
        end
        STREAM: begin
          eng_ready <= accept;
          if (accept) eng_in <= pkt.pkt_data;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AES_SEQ_BYTE_CNT_EN
  // Saturating count of packet bytes accepted since the last start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stream_bytes <= '0;
    end else if (start_ok) begin
      stream_bytes <= '0;
    end else if (accept && (stream_bytes != 32'hFFFF_FFFF)) begin
      stream_bytes <= stream_bytes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_ip_load_seq.sv
// Randomized self-checking bench for aes_ip_load_seq.
// Model: expected engine byte stream built from key/table contents.
module tb_aes_ip_load_seq;
  localparam int NA    = 8;
  localparam int LOADN = 16 + 4 * NA;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_start;
  logic [127:0] cfg_key;
  logic         addr_wr;
  logic [2:0]   addr_idx;
  logic [31:0]  addr_data;
  logic [7:0]   eng_in;
  logic         eng_key_enable;
  logic         eng_address_enable;
  logic         eng_ready;
  logic         eng_busy;
  logic         cfg_busy;
  logic         cfg_done;
`ifdef AES_SEQ_BYTE_CNT_EN
  logic [31:0]  stream_bytes;
`endif

  aes_ip_load_seq_if pkt ();

  always #5 clk = ~clk;

  aes_ip_load_seq #(.NUM_ADDR(NA), .KEY_BYTES(16)) dut (
    .clk                (clk),
    .rst                (rst),
    .cfg_start          (cfg_start),
    .cfg_key            (cfg_key),
    .addr_wr            (addr_wr),
    .addr_idx           (addr_idx),
    .addr_data          (addr_data),
    .pkt                (pkt.slave),
    .eng_in             (eng_in),
    .eng_key_enable     (eng_key_enable),
    .eng_address_enable (eng_address_enable),
    .eng_ready          (eng_ready),
    .eng_busy           (eng_busy),
    .cfg_busy           (cfg_busy),
`ifdef AES_SEQ_BYTE_CNT_EN
    .cfg_done           (cfg_done),
    .stream_bytes       (stream_bytes)
`else
    .cfg_done           (cfg_done)
`endif
  );

  int vec = 0;
  int err = 0;

  logic [31:0] tab_m [8];
  logic [7:0]  kq  [$];
  logic [7:0]  aq  [$];
  logic [7:0]  src [$];
  logic [7:0]  got [$];
  int          n_en, first_en, last_en, done_cyc, multi;
  logic        busy0, done0;
  logic [31:0] sb0;
  int          ready_bad, s_cyc;

  function automatic logic [7:0] key_byte(
    input logic [127:0] k, input int i);
    logic [127:0] t;
    t = k >> (8 * (15 - i));
    return t[7:0];
  endfunction

  function automatic logic [7:0] tab_byte(input int i);
    logic [31:0] t;
    t = tab_m[i / 4] >> (8 * (3 - (i % 4)));
    return t[7:0];
  endfunction

  task automatic write_addr(input int idx, input logic [31:0] d);
    @(negedge clk);
    addr_wr   = 1'b1;
    addr_idx  = idx[2:0];
    addr_data = d;
    @(negedge clk);
    addr_wr = 1'b0;
    if (idx < NA) tab_m[idx] = d;
  endtask

  // Pulse cfg_start and record every engine-side byte for the load window.
  task automatic run_load(input logic [127:0] k, input int inject);
    int en;
    kq.delete();
    aq.delete();
    n_en = 0; first_en = -1; last_en = -1;
    done_cyc = -1; multi = 0; sb0 = 32'hdead_beef;
    @(negedge clk);
    cfg_key   = k;
    cfg_start = 1'b1;
    for (int c = 0; c < LOADN + 8; c++) begin
      @(negedge clk);
      cfg_start = (c == inject);
      if (c == 0) begin
        busy0 = cfg_busy;
        done0 = cfg_done;
`ifdef AES_SEQ_BYTE_CNT_EN
        sb0 = stream_bytes;
`endif
      end
      en = int'(eng_key_enable) + int'(eng_address_enable)
         + int'(eng_ready);
      if (en > 1) multi++;
      if (en > 0) begin
        n_en++;
        if (first_en < 0) first_en = c;
        last_en = c;
      end
      if (eng_key_enable) kq.push_back(eng_in);
      if (eng_address_enable) aq.push_back(eng_in);
      if (cfg_done && done_cyc < 0) done_cyc = c;
    end
    cfg_start = 1'b0;
  endtask

  // Source obeys valid/ready; engine must see src exactly once, in order.
  task automatic stream(input int mode);
    int  idx;
    bit  acc;
    got.delete();
    idx = 0; acc = 1'b0; ready_bad = 0;
    for (s_cyc = 0; s_cyc < 2000; s_cyc++) begin
      @(negedge clk);
      if (eng_ready) got.push_back(eng_in);
      if (acc) idx++;
      if (idx >= src.size()) break;
      case (mode)
        1:       eng_busy = (s_cyc == 1) || (s_cyc == 2);
        2:       eng_busy = ($urandom_range(0, 2) == 0);
        default: eng_busy = 1'b0;
      endcase
      pkt.pkt_valid = (mode != 2) || ($urandom_range(0, 3) != 0);
      pkt.pkt_data  = pkt.pkt_valid ? src[idx] : 8'($urandom);
      #1;
      if (pkt.pkt_ready !== !eng_busy) ready_bad++;
      acc = pkt.pkt_valid && pkt.pkt_ready;
    end
    pkt.pkt_valid = 1'b0;
    eng_busy      = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (eng_ready) got.push_back(eng_in);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vec++;
    if ({eng_in, eng_key_enable, eng_address_enable, eng_ready,
         cfg_busy, cfg_done, pkt.pkt_ready} !== '0) begin
      err++;
      $display("FAIL reset_outputs got eng_in=%h ke=%b ae=%b er=%b busy=%b done=%b rdy=%b want all 0",
               eng_in, eng_key_enable, eng_address_enable, eng_ready,
               cfg_busy, cfg_done, pkt.pkt_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_key_load;
    int bad;
    write_addr(0, 32'ha761ca9b);
    write_addr(4, 32'h43c97381);
    for (int i = 0; i < NA; i++)
      if (i != 0 && i != 4) write_addr(i, $urandom);
    run_load(128'h000102030405060708090a0b0c0d0e0f, -1);
    vec++;
    if (first_en !== 0) begin
      err++;
      $display("FAIL key_first_cycle got %0d want 0", first_en);
    end
    bad = (kq.size() != 16);
    if (!bad)
      for (int i = 0; i < 16; i++) if (kq[i] !== 8'(i)) bad++;
    vec++;
    if (bad != 0) begin
      err++;
      $display("FAIL key_bytes got %0d bytes (%0d wrong) want 00..0f",
               kq.size(), bad);
    end
    vec++;
    if (busy0 !== 1'b1 || done0 !== 1'b0) begin
      err++;
      $display("FAIL load_start_flags got busy=%b done=%b want 1 0",
               busy0, done0);
    end
    vec++;
    if (multi != 0) begin
      err++;
      $display("FAIL onehot_enables got %0d multi cycles want 0", multi);
    end
  endtask

  task automatic test_addr_load;
    int bad;
    vec++;
    if (aq.size() != 4 * NA ||
        {aq[0], aq[1], aq[2], aq[3]} !== 32'ha761ca9b ||
        {aq[16], aq[17], aq[18], aq[19]} !== 32'h43c97381) begin
      err++;
      $display("FAIL addr_vectors got n=%0d first=%h%h%h%h want a761ca9b/43c97381",
               aq.size(), aq[0], aq[1], aq[2], aq[3]);
    end
    bad = 0;
    for (int i = 0; i < aq.size(); i++) if (aq[i] !== tab_byte(i)) bad++;
    vec++;
    if (bad != 0) begin
      err++;
      $display("FAIL addr_bytes got %0d wrong want 0", bad);
    end
    vec++;
    if (n_en != LOADN || last_en != LOADN - 1 || done_cyc != LOADN) begin
      err++;
      $display("FAIL load_timing got n=%0d last=%0d done=%0d want %0d %0d %0d",
               n_en, last_en, done_cyc, LOADN, LOADN - 1, LOADN);
    end
    vec++;
    if (cfg_busy !== 1'b0 || cfg_done !== 1'b1) begin
      err++;
      $display("FAIL stream_flags got busy=%b done=%b want 0 1",
               cfg_busy, cfg_done);
    end
  endtask

  task automatic test_back_pressure;
    src.delete();
    src.push_back(8'h61); src.push_back(8'hca);
    src.push_back(8'h9b); src.push_back(8'hbf);
    stream(1);
    vec++;
    if (got != src || s_cyc >= 2000) begin
      err++;
      $display("FAIL bp_bytes got n=%0d want 4 (61 ca 9b bf) cyc=%0d",
               got.size(), s_cyc);
    end
    vec++;
    if (ready_bad != 0) begin
      err++;
      $display("FAIL bp_ready got %0d bad cycles want 0", ready_bad);
    end
  endtask

  task automatic test_random_stream;
    src.delete();
    for (int i = 0; i < 40; i++) src.push_back(8'($urandom));
    stream(2);
    vec++;
    if (got != src || s_cyc >= 2000) begin
      err++;
      $display("FAIL rand_stream got n=%0d want %0d cyc=%0d",
               got.size(), src.size(), s_cyc);
    end
    vec++;
    if (ready_bad != 0) begin
      err++;
      $display("FAIL rand_ready got %0d bad cycles want 0", ready_bad);
    end
    vec++;
    if (eng_ready !== 1'b0 || eng_in !== src[src.size() - 1]) begin
      err++;
      $display("FAIL eng_in_hold got %h rdy=%b want %h 0",
               eng_in, eng_ready, src[src.size() - 1]);
    end
  endtask

  task automatic test_reconfigure;
    logic [127:0] k;
    int bad;
    for (int i = 0; i < NA; i++) write_addr(i, $urandom);
    k = {$urandom, $urandom, $urandom, $urandom};
    run_load(k, -1);
    bad = (kq.size() != 16) || (aq.size() != 4 * NA);
    for (int i = 0; i < kq.size(); i++) if (kq[i] !== key_byte(k, i)) bad++;
    for (int i = 0; i < aq.size(); i++) if (aq[i] !== tab_byte(i)) bad++;
    vec++;
    if (bad != 0 || done0 !== 1'b0 || n_en != LOADN) begin
      err++;
      $display("FAIL reload got bad=%0d done0=%b n=%0d want 0 0 %0d",
               bad, done0, n_en, LOADN);
    end
    k = {$urandom, $urandom, $urandom, $urandom};
    run_load(k, 20);
    bad = (kq.size() != 16);
    for (int i = 0; i < kq.size(); i++) if (kq[i] !== key_byte(k, i)) bad++;
    vec++;
    if (bad != 0 || n_en != LOADN || first_en != 0 || done_cyc != LOADN) begin
      err++;
      $display("FAIL midload_start got bad=%0d n=%0d first=%0d done=%0d want 0 %0d 0 %0d",
               bad, n_en, first_en, done_cyc, LOADN, LOADN);
    end
  endtask

  task automatic test_reset_abort;
    int bad;
    @(negedge clk);
    cfg_key   = {$urandom, $urandom, $urandom, $urandom};
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    repeat (7) @(negedge clk);
    vec++;
    if (eng_key_enable !== 1'b1 || eng_in !== key_byte(cfg_key, 7)) begin
      err++;
      $display("FAIL key_byte7 got ke=%b %h want 1 %h",
               eng_key_enable, eng_in, key_byte(cfg_key, 7));
    end
    #1 rst = 1'b1;
    #1;
    vec++;
    if ({eng_in, eng_key_enable, eng_address_enable, eng_ready,
         cfg_busy, cfg_done, pkt.pkt_ready} !== '0) begin
      err++;
      $display("FAIL abort_outputs got eng_in=%h ke=%b busy=%b want all 0",
               eng_in, eng_key_enable, cfg_busy);
    end
    for (int i = 0; i < 8; i++) tab_m[i] = '0;
    @(negedge clk);
    rst           = 1'b0;
    pkt.pkt_valid = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (pkt.pkt_ready !== 1'b0 || cfg_done !== 1'b0 ||
          eng_key_enable !== 1'b0 || eng_ready !== 1'b0) bad++;
    end
    pkt.pkt_valid = 1'b0;
    vec++;
    if (bad != 0) begin
      err++;
      $display("FAIL post_abort_idle got %0d active cycles want 0", bad);
    end
    run_load(128'h0, -1);
    bad = (aq.size() != 4 * NA);
    for (int i = 0; i < aq.size(); i++) if (aq[i] !== tab_byte(i)) bad++;
    vec++;
    if (bad != 0 || done_cyc != LOADN) begin
      err++;
      $display("FAIL table_cleared got bad=%0d done=%0d want 0 %0d",
               bad, done_cyc, LOADN);
    end
  endtask

`ifdef AES_SEQ_BYTE_CNT_EN
  task automatic test_byte_cnt;
    src.delete();
    for (int i = 0; i < 64; i++) src.push_back(8'($urandom));
    stream(0);
    vec++;
    if (stream_bytes !== 32'd64) begin
      err++;
      $display("FAIL byte_cnt got %0d want 64", stream_bytes);
    end
    run_load(128'h1, -1);
    vec++;
    if (sb0 !== 32'd0) begin
      err++;
      $display("FAIL byte_cnt_clear got %0d want 0", sb0);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_key = '0;
    addr_wr = 1'b0; addr_idx = '0; addr_data = '0;
    eng_busy = 1'b0;
    pkt.pkt_valid = 1'b0; pkt.pkt_data = '0;
    for (int i = 0; i < 8; i++) tab_m[i] = '0;
    test_reset;
    test_key_load;
    test_addr_load;
    test_back_pressure;
    test_random_stream;
    test_reconfigure;
    test_reset_abort;
`ifdef AES_SEQ_BYTE_CNT_EN
    test_byte_cnt;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
